instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Streaming RV32I instruction encoder, the inverse of the control decoder. Accepts operation descriptors (op, rd, rs1, rs2, imm) over a valid/ready handshake and emits 32-bit machine words, each paired with a sequential instruction-memory byte address. It feeds the instruction-memory loader and generates test programs for the single-cycle datapath. Covers exactly the decoder's instruction set: add, sub, and, or, lw, sw, beq.

Parameters:
ADDR_W, 10, width of the output byte address. Addresses wrap modulo 2^ADDR_W.
BASE_ADDR, 0, first address after reset or clr. Must be a multiple of 4.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
clr  in  1  synchronous clear: address returns to BASE_ADDR, output buffer emptied, err_sticky cleared
in_valid  in  1  descriptor valid
in_ready  out  1  descriptor accepted when in_valid && in_ready
in_op  in  3  0 add, 1 sub, 2 and, 3 or, 4 lw, 5 sw, 6 beq, 7 illegal
in_rd  in  5  destination register (ignored by sw and beq)
in_rs1  in  5  source register 1 / base register
in_rs2  in  5  source register 2 (ignored by lw)
in_imm  in  13  signed immediate (ignored by R-type)
out_valid  out  1  encoded word valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_instr  out  32  encoded machine word
out_addr  out  ADDR_W  byte address assigned to out_instr
err_pulse  out  1  one-cycle pulse when an accepted descriptor is rejected
err_sticky  out  1  set by err_pulse; cleared only by rst or clr
count  out  16  number of words emitted; saturates at 0xFFFF

Behaviour:
- Reset values: out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_pulse=0, err_sticky=0, count=0. The address counter is also reset to BASE_ADDR.
- Single output register stage with latency 1. A descriptor accepted in cycle N appears on out_* in cycle N+1.
- in_ready = !clr && (!out_valid || out_ready). Accepting while the buffer drains is full throughput, one word per cycle.
- out_instr and out_addr hold stable while out_valid && !out_ready.
- Address counter:
  - Holds the address of the next word to be loaded.
  - On a valid load: out_addr <= counter, and counter <= counter + 4, wrapping modulo 2^ADDR_W.
  - Rejected descriptors do not consume an address.
- Encoding uses standard RV32I fields:
  - R-type: opcode 0110011. funct3 is 000 for add/sub, 111 for and, 110 for or. funct7 is 0x20 for sub, 0x00 otherwise.
  - lw: opcode 0000011, funct3 010, imm[11:0] in bits 31:20.
  - sw: opcode 0100011, funct3 010, imm[11:5] in bits 31:25, imm[4:0] in bits 11:7.
  - beq: opcode 1100011, funct3 000, imm[12|10:5] in bits 31:25, imm[4:1|11] in bits 11:7.
- Rejection cases, evaluated on the accepted cycle:
  - in_op == 7.
  - lw/sw with imm outside -2048..2047, i.e. in_imm[12] != in_imm[11].
  - beq with odd imm, i.e. in_imm[0] == 1.
  - On rejection: err_pulse=1 in the next cycle, no word is loaded, out_valid is unchanged by the rejected descriptor, and count is unchanged.
  - An existing buffered word drains normally.
- count increments on each out handshake, i.e. out_valid && out_ready.
- clr has priority over everything:
  - Next cycle: out_valid=0, counter=BASE_ADDR, err_sticky=0.
  - A pending out_valid word is discarded, even if out_ready was high in the clr cycle. It is not counted.
  - count is not cleared by clr.
- Asynchronous rst mid-stream: all state returns to reset values immediately. No partial word is ever presented.
- Simultaneous out handshake and new accept in the same cycle: the new word replaces the old, the address advances once, and count increments once.

Decomposition:
- Shared package rv_isa_pkg:
  - op enum (OP_ADD..OP_BEQ, OP_ILL).
  - Opcode constants: OPC_RTYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH.
  - funct3/funct7 constants.
  - The same constants are to be reused by the control decoder.
- Sub-module rv_encode_core: purely combinational. Takes (op, rd, rs1, rs2, imm) and returns (instr, illegal).
- instr_encoder holds the handshake, output register, address counter, error flags and counter.

Test Plan:
- rst, then add rd=3 rs1=1 rs2=2 with out_ready=1 -> next cycle out_instr=0x002081B3, out_addr=0x000, count=1.
- Back-to-back sub(5,6,7), lw(rd=2, rs1=1, imm=8), sw(rs1=1, rs2=2, imm=4), beq(rs1=1, rs2=2, imm=-4) -> 0x407302B3@0x0, 0x0080A103@0x4, 0x0020A223@0x8, 0xFE208EE3@0xC, one per cycle.
- out_ready=0 for 5 cycles with a word loaded -> in_ready=0, out_instr/out_addr stable; after release, the next word goes to the next address with no loss or duplication.
- beq imm=3; lw imm=2048; op=7 -> err_pulse for each, err_sticky=1, no out_valid, address unchanged; next valid add lands at the unconsumed address.
- ADDR_W=4: emit 5 words -> addresses 0x0, 0x4, 0x8, 0xC, 0x0 (wrap).
- clr asserted while out_valid=1 and in_valid=1 -> next cycle out_valid=0, counter=BASE_ADDR, err_sticky=0, input not accepted; async rst pulse mid-stream -> all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// RV32I subset shared by the encoder and the control decoder:
// op codes, major opcodes, funct fields and immediate range helper.
package rv_isa_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_LW  = 3'd4,
    OP_SW  = 3'd5,
    OP_BEQ = 3'd6,
    OP_ILL = 3'd7
  } op_e;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_LSW    = 3'b010;
  localparam logic [2:0] F3_BEQ    = 3'b000;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_SUB  = 7'h20;

  // 13-bit immediate fits the 12-bit signed I/S field
  function automatic logic imm12_ok(logic [12:0] imm);
    return imm[12] == imm[11];
  endfunction

endpackage

// File: rtl/rv_encode_core.sv
// Combinational RV32I field packer for one operation descriptor.
// Flags ops that have no legal encoding.
module rv_encode_core
  import rv_isa_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [12:0] imm_i,
  output logic [31:0] instr_o,
  output logic        illegal_o
);

  logic [31:0] rtype;

  assign rtype = {F7_BASE, rs2_i, rs1_i,
                  F3_ADDSUB, rd_i, OPC_RTYPE};

  always_comb begin
    instr_o   = '0;
    illegal_o = 1'b0;
    unique case (1'b1)
      (op_i == OP_ADD): instr_o = rtype;
      (op_i == OP_SUB): begin
        instr_o = rtype;
        instr_o[31:25] = F7_SUB;
      end
      (op_i == OP_AND): begin
        instr_o = rtype;
        instr_o[14:12] = F3_AND;
      end
      (op_i == OP_OR): begin
        instr_o = rtype;
        instr_o[14:12] = F3_OR;
      end
      (op_i == OP_LW): begin
        illegal_o = !imm12_ok(imm_i);
        instr_o = {imm_i[11:0], rs1_i,
                   F3_LSW, rd_i, OPC_LOAD};
      end
      (op_i == OP_SW): begin
        illegal_o = !imm12_ok(imm_i);
        instr_o = {imm_i[11:5], rs2_i, rs1_i,
                   F3_LSW, imm_i[4:0], OPC_STORE};
      end
      (op_i == OP_BEQ): begin
        illegal_o = imm_i[0];
        instr_o = {imm_i[12], imm_i[10:5],
                   rs2_i, rs1_i, F3_BEQ,
                   imm_i[4:1], imm_i[11],
                   OPC_BRANCH};
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: valid/ready in, one registered word out
// tagged with a sequential byte address; error and emit counters.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [15:0]       count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic              vld_q, vld_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ctr_q, ctr_d;
  logic              pulse_q, pulse_d;
  logic              sticky_q, sticky_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [31:0]       enc;
  logic              illegal;
  logic              accept;

  rv_encode_core u_core (
    .op_i      (in_op),
    .rd_i      (in_rd),
    .rs1_i     (in_rs1),
    .rs2_i     (in_rs2),
    .imm_i     (in_imm),
    .instr_o   (enc),
    .illegal_o (illegal)
  );

  assign in_ready = !clr && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    vld_d    = vld_q;
    instr_d  = instr_q;
    addr_d   = addr_q;
    ctr_d    = ctr_q;
    pulse_d  = 1'b0;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clr) begin
      vld_d    = 1'b0;
      ctr_d    = BASE;
      sticky_d = 1'b0;
    end else begin
      if (vld_q && out_ready) begin
        vld_d = 1'b0;
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
      // a rejected op leaves the buffer to drain on its own
      if (accept && illegal) begin
        pulse_d  = 1'b1;
        sticky_d = 1'b1;
      end else if (accept) begin
        vld_d   = 1'b1;
        instr_d = enc;
        addr_d  = ctr_q;
        ctr_d   = ctr_q + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= 1'b0;
      instr_q  <= '0;
      addr_q   <= BASE;
      ctr_q    <= BASE;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      instr_q  <= instr_d;
      addr_q   <= addr_d;
      ctr_q    <= ctr_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = vld_q;
  assign out_instr  = instr_q;
  assign out_addr   = addr_q;
  assign err_pulse  = pulse_q;
  assign err_sticky = sticky_q;
  assign count      = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: encoding table, stall/clr/rst sequences,
// then random traffic against a behavioural model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  in_op = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [12:0] in_imm = '0;

  logic        in_ready, out_valid, err_pulse, err_sticky;
  logic [31:0] out_instr;
  logic [9:0]  out_addr;
  logic [15:0] count;

  logic        in_ready4, out_valid4, err_pulse4, err_sticky4;
  logic [31:0] out_instr4;
  logic [3:0]  out_addr4;
  logic [15:0] count4;

  int total = 0;
  int nbad  = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_pulse(err_pulse), .err_sticky(err_sticky),
    .count(count)
  );

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut4 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_instr(out_instr4), .out_addr(out_addr4),
    .err_pulse(err_pulse4), .err_sticky(err_sticky4),
    .count(count4)
  );

  function automatic int sx13(logic [12:0] v);
    return (int'(v) >= 4096) ? int'(v) - 8192 : int'(v);
  endfunction

  function automatic bit ref_legal(logic [2:0] op, logic [12:0] imm);
    int s;
    s = sx13(imm);
    if (op == 3'd7) return 1'b0;
    if (op == 3'd4 || op == 3'd5) return (s >= -2048 && s <= 2047);
    if (op == 3'd6) return (s % 2) == 0;
    return 1'b1;
  endfunction

  function automatic bit [31:0] ref_enc(logic [2:0] op, logic [4:0] rd,
                                        logic [4:0] rs1, logic [4:0] rs2,
                                        logic [12:0] imm);
    bit [31:0] u, d, s1, s2, r;
    u  = 32'(sx13(imm));
    d  = 32'(rd);
    s1 = 32'(rs1);
    s2 = 32'(rs2);
    r  = (s2 << 20) | (s1 << 15) | (d << 7) | 32'h33;
    case (op)
      3'd0: return r;
      3'd1: return r | 32'h4000_0000;
      3'd2: return r | (32'd7 << 12);
      3'd3: return r | (32'd6 << 12);
      3'd4: return ((u & 32'hFFF) << 20) | (s1 << 15) | (32'd2 << 12)
                   | (d << 7) | 32'h03;
      3'd5: return (((u >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15)
                   | (32'd2 << 12) | ((u & 32'h1F) << 7) | 32'h23;
      3'd6: return (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25)
                   | (s2 << 20) | (s1 << 15) | (((u >> 1) & 32'hF) << 8)
                   | (((u >> 11) & 1) << 7) | 32'h63;
      default: return 32'h0;
    endcase
  endfunction

  // behavioural model of the handshake/buffer
  logic        m_valid, m_pulse, m_sticky;
  logic [31:0] m_instr;
  int          m_addr, m_ctr, m_count;
  logic        m_ready, m_acc, m_bad;

  assign m_ready = !clr && (!m_valid || out_ready);
  assign m_acc   = in_valid && m_ready;
  assign m_bad   = !ref_legal(in_op, in_imm);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0; m_instr <= '0; m_addr <= 0; m_ctr <= 0;
      m_pulse <= 1'b0; m_sticky <= 1'b0; m_count <= 0;
    end else if (clr) begin
      m_valid <= 1'b0; m_ctr <= 0; m_sticky <= 1'b0; m_pulse <= 1'b0;
    end else begin
      m_pulse <= m_acc && m_bad;
      if (m_acc && m_bad) m_sticky <= 1'b1;
      if (m_valid && out_ready && m_count < 65535) m_count <= m_count + 1;
      if (m_acc && !m_bad) begin
        m_valid <= 1'b1;
        m_instr <= ref_enc(in_op, in_rd, in_rs1, in_rs2, in_imm);
        m_addr  <= m_ctr;
        m_ctr   <= (m_ctr + 4) % 1024;
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(logic v, logic [2:0] op, logic [4:0] rd,
                        logic [4:0] r1, logic [4:0] r2, logic [12:0] imm);
    in_valid = v; in_op = op; in_rd = rd;
    in_rs1 = r1; in_rs2 = r2; in_imm = imm;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [12:0] imm;
    logic [31:0] instr;
    logic        bad;
  } vec_t;

  vec_t vt[12];

  initial begin
    int exp_addr, exp_cnt;
    bit pv;
    logic [31:0] hold_i;
    logic [9:0]  hold_a;

    vt[0]  = '{3'd0, 5'd3, 5'd1, 5'd2, 13'd0,     32'h002081B3, 1'b0};
    vt[1]  = '{3'd1, 5'd5, 5'd6, 5'd7, 13'd0,     32'h407302B3, 1'b0};
    vt[2]  = '{3'd4, 5'd2, 5'd1, 5'd0, 13'd8,     32'h0080A103, 1'b0};
    vt[3]  = '{3'd5, 5'd0, 5'd1, 5'd2, 13'd4,     32'h0020A223, 1'b0};
    vt[4]  = '{3'd6, 5'd0, 5'd1, 5'd2, 13'h1FFC,  32'hFE208EE3, 1'b0};
    vt[5]  = '{3'd2, 5'd1, 5'd2, 5'd3, 13'd0,     32'h003170B3, 1'b0};
    vt[6]  = '{3'd3, 5'd4, 5'd5, 5'd6, 13'd0,     32'h0062E233, 1'b0};
    vt[7]  = '{3'd6, 5'd0, 5'd1, 5'd2, 13'd3,     32'h0,        1'b1};
    vt[8]  = '{3'd4, 5'd2, 5'd1, 5'd0, 13'h0800,  32'h0,        1'b1};
    vt[9]  = '{3'd7, 5'd1, 5'd1, 5'd1, 13'd0,     32'h0,        1'b1};
    vt[10] = '{3'd5, 5'd0, 5'd1, 5'd2, 13'h17FF,  32'h0,        1'b1};
    vt[11] = '{3'd0, 5'd3, 5'd1, 5'd2, 13'd0,     32'h002081B3, 1'b0};

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_addr", 32'(out_addr), 0);
    chk("rst_err", 32'(err_pulse), 0);
    chk("rst_sticky", 32'(err_sticky), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(in_ready), 1);

    exp_addr = 0; exp_cnt = 0; pv = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_in(1'b1, vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm);
      step();
      if (pv) exp_cnt++;
      pv = !vt[i].bad;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(!vt[i].bad));
      chk($sformatf("v%0d_err", i), 32'(err_pulse), 32'(vt[i].bad));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(exp_cnt));
      if (vt[i].bad) begin
        chk($sformatf("v%0d_sticky", i), 32'(err_sticky), 1);
      end else begin
        chk($sformatf("v%0d_instr", i), out_instr, vt[i].instr);
        chk($sformatf("v%0d_addr", i), 32'(out_addr), 32'(exp_addr));
        chk($sformatf("v%0d_addr4", i), 32'(out_addr4),
            32'(exp_addr % 16));
        exp_addr += 4;
      end
    end
    set_in(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    step();
    if (pv) exp_cnt++;
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_count", 32'(count), 32'(exp_cnt));

    // stall: word must hold while downstream is not ready
    out_ready = 1'b0;
    set_in(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 13'd0);
    step();
    hold_i = 32'h003100B3;
    hold_a = 10'(exp_addr);
    chk("stall_load", out_instr, hold_i);
    set_in(1'b1, 3'd1, 5'd4, 5'd5, 5'd6, 13'd0);
    for (int c = 0; c < 5; c++) begin
      chk("stall_ready", 32'(in_ready), 0);
      chk("stall_instr", out_instr, hold_i);
      chk("stall_addr", 32'(out_addr), 32'(hold_a));
      chk("stall_count", 32'(count), 32'(exp_cnt));
      step();
    end
    out_ready = 1'b1;
    #1 chk("release_ready", 32'(in_ready), 1);
    step();
    exp_cnt++;
    chk("release_instr", out_instr, 32'h40628233);
    chk("release_addr", 32'(out_addr), 32'(exp_addr + 4));
    chk("release_count", 32'(count), 32'(exp_cnt));
    set_in(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    step();
    exp_cnt++;
    chk("release_drain", 32'(count), 32'(exp_cnt));

    // clr with a buffered word and a pending input
    out_ready = 1'b0;
    set_in(1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    step();
    chk("preclr_valid", 32'(out_valid), 1);
    clr = 1'b1; out_ready = 1'b1;
    #1 chk("clr_ready", 32'(in_ready), 0);
    step();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_valid", 32'(out_valid), 0);
    chk("clr_sticky", 32'(err_sticky), 0);
    chk("clr_count", 32'(count), 32'(exp_cnt));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("postclr_addr", 32'(out_addr), 0);
    chk("postclr_instr", out_instr, 32'h002081B3);
    step();
    exp_cnt++;
    chk("postclr_count", 32'(count), 32'(exp_cnt));

    // async reset mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1;
    step();
    chk("prerst_valid", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_instr", out_instr, 0);
    chk("arst_addr", 32'(out_addr), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_sticky", 32'(err_sticky), 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("rnd_valid", 32'(out_valid), 32'(m_valid));
      chk("rnd_err", 32'(err_pulse), 32'(m_pulse));
      chk("rnd_sticky", 32'(err_sticky), 32'(m_sticky));
      chk("rnd_count", 32'(count), 32'(m_count));
      if (m_valid) begin
        chk("rnd_instr", out_instr, m_instr);
        chk("rnd_addr", 32'(out_addr), 32'(m_addr));
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 49) == 0);
      in_op     = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_imm    = ($urandom_range(0, 1) == 0) ? 13'($urandom)
                                              : 13'($urandom_range(0, 15)) - 13'd8;
      #1 chk("rnd_ready", 32'(in_ready), 32'(m_ready));
    end

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
